// File: rtl/wb_dma_copy.sv
// Memory-to-memory copy engine: Wishbone register slave plus a Wishbone master that copies LEN words SRC->DST.
// Latency: slave ack one cycle after strobe; master costs 5 cycles per word with a zero-wait target.
// Backpressure: master holds each bus cycle until m_ack_i/m_err_i; slave accepts every access.
module wb_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, WRW, NEXT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             done_q, done_d, ie_q, ie_d, err_q, err_d, irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdat_q, rdat_d;
  logic [31:0]      wsrc_q, wsrc_d, wdst_q, wdst_d, buf_q, buf_d;
  logic             cyc_q, cyc_d, we_q, we_d;
  logic [31:0]      adr_q, adr_d, mdat_q, mdat_d;
  logic             acc, wr, busy, start;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  // Byte selects and undecoded address bits carry no meaning here.
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  assign acc   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr    = acc & wb_we_i;
  assign busy  = (state_q != IDLE);
  assign start = wr & (wb_adr_i[3:2] == 2'd3) & wb_dat_i[0] & ~busy;

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign m_cyc_o  = cyc_q;
  assign m_stb_o  = cyc_q;
  assign m_we_o   = we_q;
  assign m_adr_o  = adr_q;
  assign m_dat_o  = mdat_q;
  assign m_sel_o  = {4{cyc_q}};
  assign irq_o    = irq_q;

  // Register read mux; status bits are assembled from live state.
  always_comb begin
    rd_mux = 32'd0;
    case (wb_adr_i[3:2])
      2'd0:    rd_mux = src_q;
      2'd1:    rd_mux = dst_q;
      2'd2:    rd_mux = 32'(len_q);
      default: rd_mux = {27'd0, err_q, ie_q, done_q, busy, 1'b0};
    endcase
  end

  // Register writes first, then the copy FSM; FSM status updates override the CPU's W1C.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ie_d    = ie_q;
    err_d   = err_q;
    ack_d   = acc;
    rdat_d  = 32'd0;
    wsrc_d  = wsrc_q;
    wdst_d  = wdst_q;
    buf_d   = buf_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    mdat_d  = mdat_q;
    irq_d   = done_q & ie_q;

    if (acc && !wb_we_i) rdat_d = rd_mux;

    if (wr) begin
      case (wb_adr_i[3:2])
        2'd0: if (!busy) src_d = {wb_dat_i[31:2], 2'b00};
        2'd1: if (!busy) dst_d = {wb_dat_i[31:2], 2'b00};
        2'd2: if (!busy) len_d = wb_dat_i[LEN_W-1:0];
        default: begin
          ie_d = wb_dat_i[3];
          if (wb_dat_i[2]) done_d = 1'b0;
          if (wb_dat_i[4]) err_d  = 1'b0;
        end
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            wsrc_d  = src_q;
            wdst_d  = dst_q;
            cnt_d   = len_q;
            state_d = RD;
          end
        end
      end
      RD: begin
        cyc_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = wsrc_q;
        mdat_d  = 32'd0;
        state_d = RDW;
      end
      RDW, WRW: begin
        // Error wins over a simultaneous ack.
        if (m_err_i || m_ack_i) begin
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          adr_d  = 32'd0;
          mdat_d = 32'd0;
          if (m_err_i) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (state_q == RDW) begin
            buf_d   = m_dat_i;
            state_d = WR;
          end else begin
            state_d = NEXT;
          end
        end
      end
      WR: begin
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = wdst_q;
        mdat_d  = buf_q;
        state_d = WRW;
      end
      NEXT: begin
        wsrc_d = wsrc_q + 32'd4;
        wdst_d = wdst_q + 32'd4;
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, including bus outputs, clears asynchronously so a reset abandons the cycle at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= 32'd0;
      wsrc_q  <= 32'd0;
      wdst_q  <= 32'd0;
      buf_q   <= 32'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      mdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      wsrc_q  <= wsrc_d;
      wdst_q  <= wdst_d;
      buf_q   <= buf_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      mdat_q  <= mdat_d;
    end
  end

endmodule

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Memory-to-memory copy engine with two Wishbone faces.
- Wishbone slave register port: attaches to a free conmax slave slot (s3) and is programmed by the CPU data master.
- Wishbone master port: attaches to a free conmax master slot (m2) and issues classic single read/write cycles to the BRAM slaves, copying LEN words from SRC to DST.
- Raises a level interrupt on completion. The interrupt is intended for a spare `int_i` bit.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  slave cycle
- wb_stb_i  in  1  slave strobe
- wb_we_i  in  1  slave write enable
- wb_adr_i  in  32  slave address; only [3:2] decoded
- wb_dat_i  in  32  slave write data
- wb_sel_i  in  4  byte selects; ignored, all writes are full-word
- wb_dat_o  out  32  slave read data
- wb_ack_o  out  1  slave acknowledge
- m_cyc_o  out  1  master cycle
- m_stb_o  out  1  master strobe
- m_we_o  out  1  master write enable
- m_adr_o  out  32  master address
- m_sel_o  out  4  master byte selects; always 4'b1111 while stb is high
- m_dat_o  out  32  master write data
- m_dat_i  in  32  master read data
- m_ack_i  in  1  master acknowledge
- m_err_i  in  1  master error
- irq_o  out  1  completion interrupt

Behaviour:
- Reset: one clock (wb_clk_i); reset is asynchronous and active-high (wb_rst_i). All registers, all outputs and the FSM state clear to 0 / IDLE. Asserting reset mid-transfer abandons the transfer immediately: cyc/stb drop asynchronously and no partial-state recovery occurs.

Register map (byte offsets):
- 0x0 SRC: RW. Bits [1:0] always read 0.
- 0x4 DST: RW. Bits [1:0] always read 0.
- 0x8 LEN: RW, LEN_W bits, zero-extended on read.
- 0xC CTRL/STATUS:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 BUSY: RO.
  - bit2 DONE: sticky, write-1-to-clear.
  - bit3 IE: RW.
  - bit4 ERR: sticky, write-1-to-clear.

Slave handshake:
- wb_ack_o pulses for exactly one cycle, in the cycle after a cycle in which wb_cyc_i & wb_stb_i & !wb_ack_o is true.
- The write takes effect on the clock edge that raises ack.
- wb_dat_o is valid while ack is high and is 0 otherwise.
- Writes to SRC/DST/LEN while BUSY are acked and discarded.
- START while BUSY is ignored.
- A CTRL write that sets START and clears DONE in the same access clears DONE first, then starts.

Master FSM: IDLE, RD, RDW, WR, WRW, NEXT.
- IDLE:
  - START with LEN=0: set DONE, no bus cycles, stay IDLE.
  - START with LEN≠0: copy SRC/DST/LEN into working counters, set BUSY, go to RD.
- RD: drive cyc=stb=1, we=0, m_adr_o = working src. Go to RDW.
- RDW: hold outputs until m_ack_i or m_err_i.
  - ack: latch m_dat_i into the data buffer, drop cyc/stb the next cycle, go to WR.
- WR: drive cyc=stb=1, we=1, m_adr_o = working dst, m_dat_o = buffer. Go to WRW.
- WRW: hold until ack/err.
  - ack: go to NEXT.
- NEXT: src+=4, dst+=4, count-=1.
  - count reaches 0: clear BUSY, set DONE, go to IDLE.
  - else: go to RD.
- cyc/stb are low for at least one cycle between successive bus cycles.
- Minimum cost is 5 cycles per word with zero-wait ack.
- m_err_i in RDW/WRW: drop cyc/stb, set ERR, clear BUSY, leave DONE unchanged, go to IDLE.
- Simultaneous ack and err: err wins.
- Addresses wrap modulo 2^32. The programmed SRC/DST/LEN registers are not modified by a transfer.
- irq_o = DONE & IE, registered, so it rises 1 cycle after DONE sets.
- m_we_o, m_dat_o and m_adr_o are 0 whenever stb is low.

Test Plan:
- Reset then read all four offsets -> all return 0x00000000; irq_o=0; m_cyc_o=0.
- SRC=0x00001000, DST=0x00001100, LEN=3, CTRL=0x9 with a zero-wait slave model -> reads at 0x1000/0x1004/0x1008 and writes to 0x1100/0x1104/0x1108 in R,W order with matching data; DONE=1 and irq_o=1 one cycle later; CTRL reads 0x0000000C.
- LEN=0, CTRL=0x1 -> no m_cyc_o activity; CTRL reads 0x4 on the next access.
- Slave inserts 3 wait states per access, LEN=2 -> stb/adr/we held stable through the waits; correct data written; 2 reads and 2 writes total.
- m_err_i on the second read of LEN=4 -> cyc drops; CTRL reads 0x10; exactly 1 write was issued; then writing CTRL=0x10 reads back 0.
- START and a SRC write while BUSY -> both acked; the transfer continues with the original SRC; SRC readback shows the old value. Async reset asserted mid-WRW -> m_cyc_o=0 immediately and all registers read 0.
